// File: rtl/select_arb_n_if.sv
// Handshake bundle for select_arb_n: CH producer channels feeding one registered consumer slot.
// master drives producer data, arbitration controls and out_ready; slave is the selector.
interface select_arb_n_if #(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  localparam int SEL_W = $clog2(CH)
);
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic                mode;
  logic [SEL_W-1:0]    order;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [SEL_W-1:0]    out_ch;

  modport master (
    output in_data, in_valid, mode, order, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, order, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/select_arb_n.sv
// N-way selector: fixed (order) or round-robin grant into a single registered output slot.
// Define SELN_XFER_CNT_EN to add a saturating 16-bit xfer_cnt of completed output transfers.
module select_arb_n #(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  select_arb_n_if.slave bus
`ifdef SELN_XFER_CNT_EN
  ,
  output logic [15:0]   xfer_cnt
`endif
);

  logic [WIDTH-1:0] w_ch_data [CH];
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_grant;
  logic             r_out_valid;
  logic             w_grant_vld;
  logic             w_load_en;
  logic             w_load;

  // Position k steps after base in the rotating scan; base is always < CH.
  function automatic logic [SEL_W-1:0] rr_pos(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CH) s = s - CH;
    return SEL_W'(s);
  endfunction

  assign w_load_en = !r_out_valid || bus.out_ready;
  assign w_load    = rst_n && w_load_en && w_grant_vld;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      assign w_ch_data[gi]    = bus.in_data[gi*WIDTH +: WIDTH];
      assign bus.in_ready[gi] = w_load && (int'(w_grant) == gi);
    end
  endgenerate

  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    if (bus.mode) begin
      // Scan from the far end so the channel nearest the pointer is written last and wins.
      for (int k = CH - 1; k >= 0; k--) begin
        if (bus.in_valid[rr_pos(r_ptr, k)]) begin
          w_grant     = rr_pos(r_ptr, k);
          w_grant_vld = 1'b1;
        end
      end
    end else if (int'(bus.order) < CH) begin
      if (bus.in_valid[bus.order]) begin
        w_grant     = bus.order;
        w_grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_data  <= w_ch_data[w_grant];
      r_out_ch    <= w_grant;
      r_out_valid <= 1'b1;
      if (bus.mode) begin
        r_ptr <= (int'(w_grant) == CH - 1) ? '0 : w_grant + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

`ifdef SELN_XFER_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (r_out_valid && bus.out_ready && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_select_arb_n.sv
// Randomised scoreboard bench for select_arb_n: a predictor pushes accepted words,
// a monitor pops and compares them as the output slot presents them.
module tb_select_arb_n;
  localparam int WIDTH = 32;
  localparam int CH    = 4;
  localparam int SEL_W = 2;

  typedef struct {
    logic [31:0] d;
    int          ch;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  select_arb_n_if #(.WIDTH(WIDTH), .CH(CH)) bif ();

`ifdef SELN_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  select_arb_n #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
`ifdef SELN_XFER_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  item_t sb_q[$];

  // Stimulus state
  logic [WIDTH-1:0] w_word [CH];
  logic [CH-1:0]    v_mask;
  logic [CH-1:0]    allow;
  logic [CH-1:0]    acc_mask;
  int               p_valid;
  int               p_ready;
  logic             cfg_mode;
  logic [SEL_W-1:0] cfg_order;
  logic             cfg_rst;

  // Reference model state
  int          m_ptr;
  logic [31:0] hold_d;
  int          hold_ch;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: expected slot contents come from the scoreboard queue head.
  initial begin : monitor
    logic  mon_ev;
    item_t mon_it;
    forever begin
      @(negedge clk);
      mon_ev = (sb_q.size() != 0);
      chk("out_valid", 32'(bif.out_valid), 32'(mon_ev));
      if (mon_ev) begin
        chk("out_data", bif.out_data, sb_q[0].d);
        chk("out_ch", 32'(bif.out_ch), sb_q[0].ch);
      end else begin
        chk("hold_data", bif.out_data, hold_d);
        chk("hold_ch", 32'(bif.out_ch), hold_ch);
      end
`ifdef SELN_XFER_CNT_EN
      chk("xfer_cnt", 32'(xfer_cnt), m_cnt);
`endif
      if (mon_ev && bif.out_ready) begin
        mon_it  = sb_q.pop_front();
        hold_d  = mon_it.d;
        hold_ch = mon_it.ch;
        if (rst_n && m_cnt < 65535) m_cnt++;
        $display("xfer ch=%0d data=%h t=%0t", mon_it.ch, mon_it.d, $time);
      end
    end
  end

  // Predictor: decides which channel the selector must accept this cycle.
  initial begin : predictor
    int          pr_g;
    int          pr_c;
    logic [CH-1:0] pr_exp;
    forever begin
      @(negedge clk);
      #1;
      pr_g   = -1;
      pr_exp = '0;
      if (!rst_n) begin
        chk("in_ready_rst", 32'(bif.in_ready), 32'(pr_exp));
        sb_q.delete();
        m_ptr    = 0;
        hold_d   = '0;
        hold_ch  = 0;
        m_cnt    = 0;
        acc_mask = '0;
      end else begin
        if (bif.mode) begin
          for (int k = 0; k < CH; k++) begin
            pr_c = (m_ptr + k) % CH;
            if (pr_g < 0 && bif.in_valid[pr_c[SEL_W-1:0]]) pr_g = pr_c;
          end
        end else if (int'(bif.order) < CH && bif.in_valid[bif.order]) begin
          pr_g = int'(bif.order);
        end
        if (pr_g >= 0 && sb_q.size() == 0) begin
          pr_exp[pr_g[SEL_W-1:0]] = 1'b1;
          sb_q.push_back('{d: w_word[pr_g], ch: pr_g});
          if (bif.mode) m_ptr = (pr_g + 1) % CH;
        end
        chk("in_ready", 32'(bif.in_ready), 32'(pr_exp));
        acc_mask = pr_exp;
      end
    end
  end

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < CH; i++) begin
        if (acc_mask[i]) v_mask[i] = 1'b0;
        if (!v_mask[i] && allow[i] && ($urandom_range(99) < p_valid)) begin
          v_mask[i] = 1'b1;
          w_word[i] = $urandom;
        end
        bif.in_data[i*WIDTH +: WIDTH] = w_word[i];
      end
      bif.in_valid  = v_mask;
      bif.mode      = cfg_mode;
      bif.order     = cfg_order;
      bif.out_ready = ($urandom_range(99) < p_ready);
      rst_n         = cfg_rst;
    end
  endtask

  initial begin : main
    for (int i = 0; i < CH; i++) w_word[i] = '0;
    v_mask = '0; allow = '0; acc_mask = '0;
    p_valid = 0; p_ready = 0;
    cfg_mode = 1'b0; cfg_order = '0; cfg_rst = 1'b0;
    m_ptr = 0; hold_d = '0; hold_ch = 0; m_cnt = 0;
    bif.in_data = '0; bif.in_valid = '0; bif.mode = 1'b0;
    bif.order = '0; bif.out_ready = 1'b0;

    step(3);
    cfg_rst = 1'b1;

    // Fixed mode on channel 2, all channels busy, consumer always ready
    cfg_mode = 1'b0; cfg_order = 2'd2; allow = '1; p_valid = 100; p_ready = 100;
    step(6);

    // Round-robin, all channels continuously valid
    cfg_mode = 1'b1;
    step(12);

    // Round-robin with only channels 1 and 3 offering new words
    allow = 4'b1010;
    step(12);

    // Backpressure then release
    allow = '1; p_ready = 0;
    step(3);
    p_ready = 100;
    step(3);

    // Fixed mode pointing at channel 1, which stops offering data
    cfg_mode = 1'b0; cfg_order = 2'd1; allow = 4'b1101;
    step(8);

    // Reset while a word is held
    cfg_mode = 1'b1; allow = '1; p_ready = 0;
    step(3);
    cfg_rst = 1'b0;
    step(2);
    cfg_rst = 1'b1; p_ready = 100;
    step(4);

    // Random mixes of mode, order, traffic density, backpressure and reset
    for (int r = 0; r < 60; r++) begin
      cfg_mode  = 1'($urandom_range(1));
      cfg_order = SEL_W'($urandom_range(CH - 1));
      allow     = CH'($urandom_range(15));
      p_valid   = int'($urandom_range(100, 10));
      p_ready   = int'($urandom_range(100, 0));
      cfg_rst   = ($urandom_range(19) != 0);
      step(int'($urandom_range(25, 5)));
    end
    cfg_rst = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
